// File: rtl/mem_stage_if.sv
// Bus bundle between execute, the Y86 memory stage, data memory and writeback.
// The slave modport is the memory stage's view. The master modport is the surrounding pipeline and memory.
`ifndef BYTE
`define BYTE [7:0]
`endif
`ifndef WORD
`define WORD [31:0]
`endif

interface mem_stage_if;
    logic         in_valid;
    logic         in_ready;
    logic `BYTE   icode_i;
    logic `WORD   valA_i;
    logic `WORD   valE_i;
    logic         dmem_req;
    logic         dmem_we;
    logic `WORD   dmem_addr;
    logic `WORD   dmem_wdata;
    logic         dmem_ack;
    logic `WORD   dmem_rdata;
    logic         out_valid;
    logic `BYTE   icode_o;
    logic `WORD   valE_o;
    logic `WORD   valM_o;
    logic         err_o;

    modport slave (
        input  in_valid, icode_i, valA_i, valE_i, dmem_ack, dmem_rdata,
        output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               out_valid, icode_o, valE_o, valM_o, err_o
    );

    modport master (
        output in_valid, icode_i, valA_i, valE_i, dmem_ack, dmem_rdata,
        input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               out_valid, icode_o, valE_o, valM_o, err_o
    );
endinterface

// File: rtl/mem_stage.sv
// Y86 memory stage: performs at most one data-memory access per instruction and emits one beat to writeback.
// Define MEM_TIMEOUT_EN to abort an access after TIMEOUT cycles without an ack.
`ifndef BYTE
`define BYTE [7:0]
`endif
`ifndef WORD
`define WORD [31:0]
`endif

module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    localparam logic [7:0] I_RMMOVL = 8'h4;
    localparam logic [7:0] I_MRMOVL = 8'h5;
    localparam logic [7:0] I_CALL   = 8'h8;
    localparam logic [7:0] I_RET    = 8'h9;
    localparam logic [7:0] I_PUSHL  = 8'hA;
    localparam logic [7:0] I_POPL   = 8'hB;

    logic [0:0]  r_state;
    logic        r_req;
    logic        r_we;
    logic `WORD  r_addr;
    logic `WORD  r_wdata;
    logic        r_isRead;
    logic `BYTE  r_pendIcode;
    logic `WORD  r_pendValE;
    logic        r_outValid;
    logic `BYTE  r_icodeOut;
    logic `WORD  r_valEOut;
    logic `WORD  r_valMOut;

    logic        w_accept;
    logic        w_read;
    logic        w_write;
    logic `WORD  w_addr;
    logic        w_ack;
    logic        w_timeout;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_ack    = (r_state == S_ACCESS) && bus.dmem_ack;

    // Stack pops and returns read through the old stack pointer, which upstream routes on valA.
    always_comb begin
        w_read  = 1'b0;
        w_write = 1'b0;
        w_addr  = bus.valE_i;
        case (bus.icode_i)
            I_RMMOVL, I_PUSHL, I_CALL: w_write = 1'b1;
            I_MRMOVL:                  w_read  = 1'b1;
            I_POPL, I_RET: begin
                w_read = 1'b1;
                w_addr = bus.valA_i;
            end
            default: ;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    assign w_timeout = (r_state == S_ACCESS) && !bus.dmem_ack
                       && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == S_ACCESS && !bus.dmem_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept && !(w_read || w_write)) begin
                r_err <= 1'b0;
            end else if (w_ack) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.err_o = r_err;
`else
    localparam int unusedTimeout = TIMEOUT;

    assign w_timeout = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_isRead    <= 1'b0;
            r_pendIcode <= '0;
            r_pendValE  <= '0;
            r_outValid  <= 1'b0;
            r_icodeOut  <= '0;
            r_valEOut   <= '0;
            r_valMOut   <= '0;
        end else begin
            r_outValid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_read || w_write) begin
                            r_state     <= S_ACCESS;
                            r_req       <= 1'b1;
                            r_we        <= w_write;
                            r_addr      <= w_addr;
                            r_wdata     <= bus.valA_i;
                            r_isRead    <= w_read;
                            r_pendIcode <= bus.icode_i;
                            r_pendValE  <= bus.valE_i;
                        end else begin
                            r_outValid <= 1'b1;
                            r_icodeOut <= bus.icode_i;
                            r_valEOut  <= bus.valE_i;
                            r_valMOut  <= '0;
                        end
                    end
                end
                default: begin
                    // An ack in the final watchdog cycle still completes the access normally.
                    if (w_ack || w_timeout) begin
                        r_state    <= S_IDLE;
                        r_req      <= 1'b0;
                        r_outValid <= 1'b1;
                        r_icodeOut <= r_pendIcode;
                        r_valEOut  <= r_pendValE;
                        r_valMOut  <= (w_ack && r_isRead) ? bus.dmem_rdata : '0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.dmem_req   = r_req;
    assign bus.dmem_we    = r_we;
    assign bus.dmem_addr  = r_addr;
    assign bus.dmem_wdata = r_wdata;
    assign bus.out_valid  = r_outValid;
    assign bus.icode_o    = r_icodeOut;
    assign bus.valE_o     = r_valEOut;
    assign bus.valM_o     = r_valMOut;

endmodule
